fir_frame_ctrl: RTL and testbench

Frame sequencer placed in front of and behind the free-running `fir` datapath (16-bit in, WIDTH+3-bit out).
- Holds the filter cleared between frames.
- Issues exactly FRAME_LEN sample slots, then FLUSH_LEN zero slots to push the pipeline out.
- Tags the returning filter outputs with valid/last so downstream capture needs no cycle counting.
- Replaces bench-side hand sequencing of reset release, sample feed and zero flush.

---
 rtl/fir_ctrl_pkg.sv | 17 +
 rtl/fir_tag_pipe.sv | 39 +++
 rtl/fir_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_fir_frame_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - state encoding and counter sizing for the fir frame controller
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width that holds 0..n inclusive, so a counter reaching n never wraps.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_tag_pipe.sv
// rtl/fir_tag_pipe.sv - {valid,last} delay line that tracks slots through the fir latency
module fir_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o,
  output logic busy_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= valid_i & last_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign last_o  = last_q[DEPTH-1];
  assign busy_o  = |valid_q;

endmodule

// File: rtl/fir_frame_ctrl.sv
// rtl/fir_frame_ctrl.sv - frame sequencer around the fir datapath: slot issue, zero flush, output tagging
module fir_frame_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_W     = WIDTH + 3,
  parameter int FRAME_LEN = 1000,
  parameter int FLUSH_LEN = 5,
  parameter int LATENCY   = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             fir_rst_n,
  output logic [WIDTH-1:0] fir_in,
  input  logic [OUT_W-1:0] fir_out,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int TOTAL = FRAME_LEN + FLUSH_LEN;
  localparam int CNT_W = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(TOTAL - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic               fir_rst_n_q;
  logic [WIDTH-1:0]   fir_in_q, fir_in_d;
  logic               tag_valid_q, tag_valid_d;
  logic               tag_last_q, tag_last_d;
  logic               underrun_q, underrun_d;
  logic               m_valid_q, m_last_q;
  logic [OUT_W-1:0]   m_data_q;
  logic               pipe_valid, pipe_last, pipe_busy;
  logic               slot_now, abort_now;

  assign abort_now = abort && (state_q != ST_IDLE);
  assign slot_now  = (state_q == ST_RUN) || (state_q == ST_FLUSH);

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    fir_in_d    = '0;
    tag_valid_d = 1'b0;
    tag_last_d  = 1'b0;
    underrun_d  = underrun_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          slot_cnt_d = '0;
          underrun_d = 1'b0;
        end
      end
      ST_RUN: begin
        fir_in_d = s_valid ? s_data : '0;
        if (!s_valid) underrun_d = 1'b1;
        if (slot_cnt_q == RUN_END) state_d = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (slot_cnt_q == LAST_SLOT) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty means the final slot's tag has left the pipe and reached m_valid.
        if (!tag_valid_q && !pipe_busy) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (slot_now) begin
      slot_cnt_d  = slot_cnt_q + 1'b1;
      tag_valid_d = 1'b1;
      tag_last_d  = (slot_cnt_q == LAST_SLOT);
    end
    if (abort_now) begin
      state_d     = ST_IDLE;
      fir_in_d    = '0;
      tag_valid_d = 1'b0;
      tag_last_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_cnt_q  <= '0;
      fir_rst_n_q <= 1'b0;
      fir_in_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_last_q  <= 1'b0;
      underrun_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      fir_rst_n_q <= (state_d != ST_IDLE);
      fir_in_q    <= fir_in_d;
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
      underrun_q  <= underrun_d;
      if (abort_now) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        m_valid_q <= pipe_valid;
        m_last_q  <= pipe_last;
        if (pipe_valid) m_data_q <= fir_out;
      end
    end
  end

  // tag_valid_q sits beside fir_in_q; the pipe then mirrors the fir latency.
  fir_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk_i   (CLK),
    .rst_i   (rst),
    .clr_i   (abort_now),
    .valid_i (tag_valid_q),
    .last_i  (tag_last_q),
    .valid_o (pipe_valid),
    .last_o  (pipe_last),
    .busy_o  (pipe_busy)
  );

  assign s_ready   = (state_q == ST_RUN);
  assign fir_rst_n = fir_rst_n_q;
  assign fir_in    = fir_in_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) && !abort;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// tb/tb_fir_frame_ctrl.sv - directed bench for fir_frame_ctrl with a LATENCY-cycle pass-through fir stub
module tb_fir_frame_ctrl;

  logic        CLK = 1'b0;
  logic        rst, start, abort, s_valid;
  logic [15:0] s_data;
  logic        s_ready, fir_rst_n;
  logic [15:0] fir_in;
  logic [18:0] fir_out;
  logic        m_valid, m_last, busy, done, underrun;
  logic [18:0] m_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] smp [8];
  logic [7:0]  vmask;
  logic [18:0] exp_d [10];

  logic [18:0] bd[$];
  logic        bl[$];
  int          bc[$];
  int          dc[$];
  int          cyc = 0;

  always #5 CLK = ~CLK;

  fir_frame_ctrl #(
    .WIDTH(16), .OUT_W(19), .FRAME_LEN(8), .FLUSH_LEN(2), .LATENCY(2)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_rst_n(fir_rst_n), .fir_in(fir_in), .fir_out(fir_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .underrun(underrun)
  );

  logic [15:0] st1_q, st2_q;
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      st1_q <= '0;
      st2_q <= '0;
    end else if (!fir_rst_n) begin
      st1_q <= '0;
      st2_q <= '0;
    end else begin
      st1_q <= fir_in;
      st2_q <= st1_q;
    end
  end
  assign fir_out = fir_rst_n ? {{3{st2_q[15]}}, st2_q} : 19'd0;

  always @(negedge CLK) begin
    cyc++;
    if (m_valid) begin
      bd.push_back(m_data);
      bl.push_back(m_last);
      bc.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int start_slot, input bit start_in_done);
    bit got;
    got = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_s_ready", 32'(s_ready), 32'd1);
    chk("run_fir_rst_n", 32'(fir_rst_n), 32'd1);
    for (int i = 0; i < 8; i++) begin
      s_valid = vmask[i];
      s_data  = smp[i];
      start   = (i == start_slot);
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
    start   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) begin
        got   = 1'b1;
        start = start_in_done;
      end
      tick();
      start = 1'b0;
    end
    chk("done_seen", 32'(got), 32'd1);
    tick();
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input int idx0, input int nd0);
    int n;
    logic [18:0] d;
    logic l;
    n = bd.size() - idx0;
    chk("beat_count", 32'(n), 32'd10);
    for (int i = 0; i < 10; i++) begin
      d = (idx0 + i < bd.size()) ? bd[idx0+i] : 19'bx;
      l = (idx0 + i < bl.size()) ? bl[idx0+i] : 1'bx;
      chk($sformatf("beat%0d_data", i), 32'(d), 32'(exp_d[i]));
      chk($sformatf("beat%0d_last", i), 32'(l), (i == 9) ? 32'd1 : 32'd0);
    end
    chk("contiguous", (n >= 10) ? 32'(bc[idx0+9] - bc[idx0]) : 32'hFFFF_FFFF, 32'd9);
    chk("done_count", 32'(dc.size() - nd0), 32'd1);
    chk("done_after_last",
        (n >= 10 && dc.size() > nd0) ? 32'(dc[nd0] - bc[idx0+9]) : 32'hFFFF_FFFF, 32'd1);
  endtask

  int idx0, nd0, nb;

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    chk("rst_fir_rst_n", 32'(fir_rst_n), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // nominal frame
    smp   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vmask = 8'hFF;
    exp_d = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8, 19'd0, 19'd0};
    idx0 = bd.size(); nd0 = dc.size();
    run_frame(-1, 1'b0);
    check_frame(idx0, nd0);
    chk("nominal_underrun", 32'(underrun), 32'd0);

    // signed extremes
    smp   = '{16'hC000, 16'hFFFF, 16'h7FFF, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    exp_d = '{19'h7C000, 19'h7FFFF, 19'h07FFF, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8, 19'd0, 19'd0};
    idx0 = bd.size(); nd0 = dc.size();
    run_frame(-1, 1'b0);
    check_frame(idx0, nd0);

    // underrun on slot 3
    smp   = '{16'd1, 16'd2, 16'd3, 16'h5555, 16'd5, 16'd6, 16'd7, 16'd8};
    vmask = 8'b1111_0111;
    exp_d = '{19'd1, 19'd2, 19'd3, 19'd0, 19'd5, 19'd6, 19'd7, 19'd8, 19'd0, 19'd0};
    idx0 = bd.size(); nd0 = dc.size();
    run_frame(-1, 1'b0);
    check_frame(idx0, nd0);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // abort on slot 5 with an earlier underrun on slot 2
    idx0 = bd.size(); nd0 = dc.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = (i != 2);
      s_data  = 16'(i + 1);
      tick();
    end
    s_valid = 1'b1; s_data = 16'd6; abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0; s_data = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fir_rst_n", 32'(fir_rst_n), 32'd0);
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_underrun_kept", 32'(underrun), 32'd1);
    nb = bd.size();
    for (int i = 0; i < 8; i++) tick();
    chk("abort_beats_before", 32'(nb - idx0), 32'd2);
    chk("abort_no_more_beats", 32'(bd.size()), 32'(nb));
    chk("abort_no_done", 32'(dc.size()), 32'(nd0));

    smp   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vmask = 8'hFF;
    exp_d = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8, 19'd0, 19'd0};
    idx0 = bd.size(); nd0 = dc.size();
    run_frame(-1, 1'b0);
    check_frame(idx0, nd0);
    chk("restart_underrun_clear", 32'(underrun), 32'd0);

    // start pulses in RUN and DONE are ignored
    idx0 = bd.size(); nd0 = dc.size();
    run_frame(4, 1'b1);
    check_frame(idx0, nd0);
    tick();
    chk("start_in_done_ignored", 32'(busy), 32'd0);

    // async reset in the middle of FLUSH
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = smp[i];
      tick();
    end
    s_valid = 1'b0; s_data = '0;
    chk("flush_m_valid", 32'(m_valid), 32'd1);
    chk("flush_m_data", 32'(m_data), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fir_rst_n", 32'(fir_rst_n), 32'd0);
    chk("arst_fir_in", 32'(fir_in), 32'd0);
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_last", 32'(m_last), 32'd0);
    chk("arst_m_data", 32'(m_data), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_stays_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
